// File: rtl/riscv_imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot-time loader.
// The loader takes the slave modport; the byte source / memory side takes master.
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_imem_loader_if;
  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_rx_ready;
  logic              o_imem_wr_en;
  logic [`XLEN-1:0]  o_imem_wr_addr;
  logic [`XLEN-1:0]  o_imem_wr_data;

  modport slave (
    input  i_rx_valid,
    input  i_rx_data,
    output o_rx_ready,
    output o_imem_wr_en,
    output o_imem_wr_addr,
    output o_imem_wr_data
  );

  modport master (
    output i_rx_valid,
    output i_rx_data,
    input  o_rx_ready,
    input  o_imem_wr_en,
    input  o_imem_wr_addr,
    input  o_imem_wr_data
  );
endinterface

// File: rtl/riscv_imem_loader.sv
// Framed byte-stream program loader: assembles little-endian words into imem,
// checks the XOR checksum and releases the RV32I core from reset on success.
module riscv_imem_loader #(
  parameter int IMEM_DEPTH = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  riscv_imem_loader_if.slave bus,
  output logic               o_cpu_rstn,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [7:0]  csum;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;

  logic        accept;
  logic [15:0] len_full;

  assign accept   = bus.i_rx_valid && bus.o_rx_ready;
  assign len_full = {bus.i_rx_data, len[7:0]};

  // The length is range-checked against IMEM_DEPTH before any write can occur,
  // so word addresses never wrap; the 4th byte of a word goes straight into the
  // registered write data alongside the three lanes already assembled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= LEN0;
      len                <= '0;
      word_idx           <= '0;
      csum               <= '0;
      byte_cnt           <= '0;
      asm_q              <= '0;
      bus.o_rx_ready     <= 1'b1;
      bus.o_imem_wr_en   <= 1'b0;
      bus.o_imem_wr_addr <= '0;
      bus.o_imem_wr_data <= '0;
      o_cpu_rstn         <= 1'b0;
      o_done             <= 1'b0;
      o_err              <= 1'b0;
    end else begin
      bus.o_imem_wr_en <= 1'b0;
      if (accept) begin
        case (state)
          LEN0: begin
            len[7:0] <= bus.i_rx_data;
            csum     <= csum ^ bus.i_rx_data;
            state    <= LEN1;
          end
          LEN1: begin
            len[15:8] <= bus.i_rx_data;
            csum      <= csum ^ bus.i_rx_data;
            if (int'(len_full) > IMEM_DEPTH) begin
              state          <= ERR;
              bus.o_rx_ready <= 1'b0;
              o_err          <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum     <= csum ^ bus.i_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_q[7:0]   <= bus.i_rx_data;
              2'd1: asm_q[15:8]  <= bus.i_rx_data;
              2'd2: asm_q[23:16] <= bus.i_rx_data;
              default: begin
                bus.o_imem_wr_en   <= 1'b1;
                bus.o_imem_wr_addr <= `XLEN'({word_idx, 2'b00});
                bus.o_imem_wr_data <= `XLEN'({bus.i_rx_data, asm_q});
                word_idx           <= word_idx + 16'd1;
                if (word_idx == len - 16'd1) begin
                  state <= CSUM;
                end
              end
            endcase
          end
          CSUM: begin
            bus.o_rx_ready <= 1'b0;
            if (bus.i_rx_data == csum) begin
              state      <= RUN;
              o_done     <= 1'b1;
              o_cpu_rstn <= 1'b1;
            end else begin
              state <= ERR;
              o_err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Self-checking bench for riscv_imem_loader: a frame-history reference model
// checked every cycle, plus literal expectations for the directed frames.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_imem_loader;
  localparam int DEPTH_A = 1024;
  localparam int DEPTH_B = 4;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  riscv_imem_loader_if bus_a();
  riscv_imem_loader_if bus_b();

  logic cpu_rstn_a, done_a, err_a;
  logic cpu_rstn_b, done_b, err_b;

  assign bus_a.i_rx_valid = rx_valid && !sel;
  assign bus_a.i_rx_data  = rx_data;
  assign bus_b.i_rx_valid = rx_valid && sel;
  assign bus_b.i_rx_data  = rx_data;

  riscv_imem_loader #(.IMEM_DEPTH(DEPTH_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a),
    .o_cpu_rstn(cpu_rstn_a), .o_done(done_a), .o_err(err_a)
  );

  riscv_imem_loader #(.IMEM_DEPTH(DEPTH_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b),
    .o_cpu_rstn(cpu_rstn_b), .o_done(done_b), .o_err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model for dut_a: everything follows from the bytes accepted since reset.
  logic [7:0]  frm[$];
  logic [7:0]  m_xor = 8'h00;
  logic        m_ready = 1'b1, m_wr_en = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = 32'h0, m_data = 32'h0;
  bit          m_live = 1'b0;

  always @(posedge clk) begin : model
    int n, k, len, total;
    bit ovf;
    if (rst) begin
      frm.delete();
      m_xor = 8'h00; m_ready = 1'b1; m_wr_en = 1'b0; m_addr = 32'h0; m_data = 32'h0;
      m_done = 1'b0; m_err = 1'b0; m_live = 1'b1;
    end else begin
      m_wr_en = 1'b0;
      if (bus_a.i_rx_valid && m_ready) begin
        frm.push_back(bus_a.i_rx_data);
        m_xor = m_xor ^ bus_a.i_rx_data;
        n   = frm.size();
        k   = n - 1;
        len = (n >= 2) ? int'({frm[1], frm[0]}) : 0;
        ovf = (n >= 2) && (len > DEPTH_A);
        total = 3 + 4 * len;
        if (!ovf && k >= 2 && k < 2 + 4 * len && (k - 2) % 4 == 3) begin
          m_wr_en = 1'b1;
          m_addr  = 32'(((k - 2) / 4) * 4);
          m_data  = {frm[k], frm[k-1], frm[k-2], frm[k-3]};
        end
        m_done  = !ovf && (n == total) && (m_xor == 8'h00);
        m_err   = ovf || ((n == total) && (m_xor != 8'h00));
        m_ready = (n < 2) || (!ovf && n < total);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check_output("rx_ready",  32'(bus_a.o_rx_ready),   32'(m_ready));
      check_output("wr_en",     32'(bus_a.o_imem_wr_en), 32'(m_wr_en));
      check_output("wr_addr",   bus_a.o_imem_wr_addr,    m_addr);
      check_output("wr_data",   bus_a.o_imem_wr_data,    m_data);
      check_output("done",      32'(done_a),             32'(m_done));
      check_output("err",       32'(err_a),              32'(m_err));
      check_output("cpu_rstn",  32'(cpu_rstn_a),         32'(m_done));
    end
  end

  logic [63:0] wr_log_a[$];
  logic [63:0] wr_log_b[$];

  always @(negedge clk) begin
    if (bus_a.o_imem_wr_en === 1'b1) wr_log_a.push_back({bus_a.o_imem_wr_addr, bus_a.o_imem_wr_data});
    if (bus_b.o_imem_wr_en === 1'b1) wr_log_b.push_back({bus_b.o_imem_wr_addr, bus_b.o_imem_wr_data});
  end

  function automatic logic cur_ready();
    return sel ? bus_b.o_rx_ready : bus_a.o_rx_ready;
  endfunction

  // Drives one byte per accepted transfer, with optional random idle gaps.
  task automatic apply_stimulus(input byte_q_t bytes, input int max_gap);
    int gap, waited;
    for (int i = 0; i < bytes.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = bytes[i];
      waited   = 0;
      while (cur_ready() !== 1'b1) begin
        if (waited >= 50) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL byte_accept: byte %0d not accepted, rx_ready %b required 1", i, cur_ready());
          rx_valid = 1'b0;
          return;
        end
        @(negedge clk);
        waited++;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic byte_q_t make_frame(input int len, input bit bad);
    byte_q_t q;
    logic [7:0] x;
    q.push_back(len[7:0]);
    q.push_back(len[15:8]);
    for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    return q;
  endfunction

  logic [87:0] nom_bits = 88'h02_00_13_00_00_00_93_00_A0_00_22;
  byte_q_t     nominal, bad_nom, empty_frm, partial, ovf_frm;

  task automatic check_nominal_writes(input string tag);
    check_output({tag, "_wr_count"}, 32'(wr_log_a.size()), 32'd2);
    if (wr_log_a.size() == 2) begin
      check_output({tag, "_wr0"}, wr_log_a[0][31:0], 32'h00000013);
      check_output({tag, "_wr0_addr"}, wr_log_a[0][63:32], 32'h0);
      check_output({tag, "_wr1"}, wr_log_a[1][31:0], 32'h00A00093);
      check_output({tag, "_wr1_addr"}, wr_log_a[1][63:32], 32'h4);
    end
  endtask

  initial begin
    for (int i = 0; i < 11; i++) nominal.push_back(nom_bits[87 - 8*i -: 8]);
    bad_nom = nominal;
    bad_nom[10] = 8'h23;
    for (int i = 0; i < 3; i++) empty_frm.push_back(8'h00);
    for (int i = 0; i < 5; i++) partial.push_back(nominal[i]);
    ovf_frm.push_back(8'h05);
    ovf_frm.push_back(8'h00);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_output("rst_ready", 32'(bus_a.o_rx_ready), 32'd1);
    check_output("rst_rstn",  32'(cpu_rstn_a), 32'd0);
    check_output("rst_b_ready", 32'(bus_b.o_rx_ready), 32'd1);
    check_output("rst_b_err", 32'(err_b), 32'd0);

    // Nominal frame, back to back.
    wr_log_a.delete();
    apply_stimulus(nominal, 0);
    check_output("nom_done", 32'(done_a), 32'd1);
    check_output("nom_rstn", 32'(cpu_rstn_a), 32'd1);
    check_output("nom_ready", 32'(bus_a.o_rx_ready), 32'd0);
    check_nominal_writes("nom");
    idle(3);

    // Reset from RUN drops the core reset again.
    do_reset();
    check_output("run_rst_rstn", 32'(cpu_rstn_a), 32'd0);
    check_output("run_rst_done", 32'(done_a), 32'd0);

    // Same frame with random valid gaps.
    wr_log_a.delete();
    apply_stimulus(nominal, 3);
    check_output("gap_done", 32'(done_a), 32'd1);
    check_nominal_writes("gap");

    // Checksum mismatch: writes still happen, error persists.
    do_reset();
    wr_log_a.delete();
    apply_stimulus(bad_nom, 0);
    check_output("bad_err", 32'(err_a), 32'd1);
    idle(100);
    check_output("bad_err_hold", 32'(err_a), 32'd1);
    check_output("bad_done", 32'(done_a), 32'd0);
    check_output("bad_rstn", 32'(cpu_rstn_a), 32'd0);
    check_output("bad_ready", 32'(bus_a.o_rx_ready), 32'd0);
    check_nominal_writes("bad");

    // Empty program.
    do_reset();
    wr_log_a.delete();
    apply_stimulus(empty_frm, 0);
    check_output("empty_done", 32'(done_a), 32'd1);
    check_output("empty_wr_count", 32'(wr_log_a.size()), 32'd0);

    // Reset mid-load, then a full reload.
    do_reset();
    apply_stimulus(partial, 0);
    do_reset();
    check_output("mid_ready", 32'(bus_a.o_rx_ready), 32'd1);
    check_output("mid_addr", bus_a.o_imem_wr_addr, 32'h0);
    check_output("mid_data", bus_a.o_imem_wr_data, 32'h0);
    check_output("mid_done", 32'(done_a), 32'd0);
    wr_log_a.delete();
    apply_stimulus(nominal, 0);
    check_output("mid_reload_done", 32'(done_a), 32'd1);
    check_nominal_writes("mid");

    // Small-memory instance: overflow and exactly-full boundary.
    sel = 1'b1;
    do_reset();
    wr_log_b.delete();
    apply_stimulus(ovf_frm, 0);
    check_output("ovf_err", 32'(err_b), 32'd1);
    check_output("ovf_ready", 32'(bus_b.o_rx_ready), 32'd0);
    check_output("ovf_done", 32'(done_b), 32'd0);
    idle(20);
    check_output("ovf_no_write", 32'(wr_log_b.size()), 32'd0);
    do_reset();
    wr_log_b.delete();
    apply_stimulus(make_frame(DEPTH_B, 1'b0), 1);
    check_output("full_b_done", 32'(done_b), 32'd1);
    check_output("full_b_wr_count", 32'(wr_log_b.size()), 32'd4);
    if (wr_log_b.size() == 4) check_output("full_b_last_addr", wr_log_b[3][63:32], 32'hC);
    sel = 1'b0;

    // Randomized frames against the model.
    for (int t = 0; t < 30; t++) begin
      do_reset();
      apply_stimulus(make_frame(int'($urandom_range(0, 8)), $urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 3)));
      idle(int'($urandom_range(1, 4)));
    end

    // Largest legal program, and one word past it.
    do_reset();
    wr_log_a.delete();
    apply_stimulus(make_frame(DEPTH_A, 1'b0), 0);
    check_output("max_done", 32'(done_a), 32'd1);
    check_output("max_wr_count", 32'(wr_log_a.size()), 32'(DEPTH_A));
    if (wr_log_a.size() > 0) check_output("max_last_addr", wr_log_a[wr_log_a.size()-1][63:32], 32'hFFC);
    do_reset();
    wr_log_a.delete();
    ovf_frm[0] = 8'h01;
    ovf_frm[1] = 8'h04;
    apply_stimulus(ovf_frm, 0);
    check_output("ovf_a_err", 32'(err_a), 32'd1);
    idle(10);
    check_output("ovf_a_no_write", 32'(wr_log_a.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, limit reached");
    $fatal(1);
  end

endmodule
